// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Purpose  : 32-bit memory-bus slave driving a 16-bit asynchronous SRAM as two
//            halfword accesses (low half first), with byte lanes mapped to
//            ub_n/lb_n. Optional single-entry read buffer: SRAM_CTRL_READ_BUF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              bus_stb_i,
  input  logic              bus_we_i,
  input  logic [31:0]       bus_adr_i,
  input  logic [31:0]       bus_dat_i,
  input  logic [3:0]        bus_bytesel_i,
  output logic [31:0]       bus_dat_o,
  output logic              bus_ack_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [15:0]       sram_dq_i,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic              sram_ub_n_o,
  output logic              sram_lb_n_o
);

  localparam logic [2:0] c_wait_last = 3'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP_LO = 3'd1,
    S_STRB_LO  = 3'd2,
    S_SETUP_HI = 3'd3,
    S_STRB_HI  = 3'd4,
    S_ACK      = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [ADDR_W-2:0]  r_word;
  logic               r_we;
  logic [31:0]        r_dat;
  logic [3:0]         r_sel;
  logic [2:0]         r_wait;
  logic [31:0]        r_rdata;

  logic [ADDR_W-2:0]  w_word;
  logic               w_access;
  logic               w_strobe;
  logic               w_half;
  logic               w_strb_done;
  logic               w_hit;
  logic [31:0]        w_hit_data;
  logic               w_unused_adr;

  assign w_word       = bus_adr_i[ADDR_W:2];
  assign w_strb_done  = (r_wait == c_wait_last);
  assign w_unused_adr = ^{bus_adr_i[31:ADDR_W+1], bus_adr_i[1:0]};
  assign bus_dat_o    = r_rdata;

`ifdef SRAM_CTRL_READ_BUF_EN
  logic               r_buf_valid;
  logic [ADDR_W-2:0]  r_buf_word;
  logic [31:0]        r_buf_data;

  // Hits return only the requested bytes; misses return whole accessed halves.
  assign w_hit      = bus_stb_i && !bus_we_i && r_buf_valid && (r_buf_word == w_word);
  assign w_hit_data = r_buf_data & {{8{bus_bytesel_i[3]}}, {8{bus_bytesel_i[2]}},
                                    {8{bus_bytesel_i[1]}}, {8{bus_bytesel_i[0]}}};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_buf_valid <= 1'b0;
      r_buf_word  <= '0;
      r_buf_data  <= '0;
    end else begin
      if (r_state == S_IDLE && bus_stb_i && bus_we_i && (w_word == r_buf_word)) begin
        r_buf_valid <= 1'b0;
      end
      if (r_state == S_ACK && !r_we && r_sel == 4'hF) begin
        r_buf_valid <= 1'b1;
        r_buf_word  <= r_word;
        r_buf_data  <= r_rdata;
      end
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_access     = 1'b0;
    w_strobe     = 1'b0;
    w_half       = 1'b0;
    bus_ack_o    = 1'b0;
    sram_ce_n_o  = 1'b1;
    sram_oe_n_o  = 1'b1;
    sram_we_n_o  = 1'b1;
    sram_ub_n_o  = 1'b1;
    sram_lb_n_o  = 1'b1;
    sram_dq_oe_o = 1'b0;
    sram_dq_o    = '0;

    case (r_state)
      S_IDLE: begin
        if (bus_stb_i) begin
          if (w_hit) begin
            w_next = S_ACK;
          end else if (bus_bytesel_i[1:0] != 2'b00) begin
            w_next = S_SETUP_LO;
          end else if (bus_bytesel_i[3:2] != 2'b00) begin
            w_next = S_SETUP_HI;
          end else begin
            w_next = S_ACK;
          end
        end
      end
      S_SETUP_LO: begin
        w_access = 1'b1;
        w_next   = S_STRB_LO;
      end
      S_STRB_LO: begin
        w_access = 1'b1;
        w_strobe = 1'b1;
        if (w_strb_done) begin
          w_next = (r_sel[3:2] != 2'b00) ? S_SETUP_HI : S_ACK;
        end
      end
      S_SETUP_HI: begin
        w_access = 1'b1;
        w_half   = 1'b1;
        w_next   = S_STRB_HI;
      end
      S_STRB_HI: begin
        w_access = 1'b1;
        w_half   = 1'b1;
        w_strobe = 1'b1;
        if (w_strb_done) begin
          w_next = S_ACK;
        end
      end
      S_ACK: begin
        bus_ack_o = 1'b1;
        w_next    = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    sram_addr_o = {r_word, w_half};

    if (w_access) begin
      sram_ce_n_o = 1'b0;
      sram_ub_n_o = w_half ? ~r_sel[3] : ~r_sel[1];
      sram_lb_n_o = w_half ? ~r_sel[2] : ~r_sel[0];
      if (r_we) begin
        sram_dq_oe_o = 1'b1;
        sram_dq_o    = w_half ? r_dat[31:16] : r_dat[15:0];
        sram_we_n_o  = ~w_strobe;
      end else begin
        sram_oe_n_o  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_word  <= '0;
      r_we    <= 1'b0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_wait  <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && bus_stb_i) begin
        r_word  <= w_word;
        r_we    <= bus_we_i;
        r_dat   <= bus_dat_i;
        r_sel   <= bus_bytesel_i;
        // Clearing here makes halves that are never accessed read back as 0.
        r_rdata <= w_hit ? w_hit_data : '0;
      end
      if (w_strobe) begin
        r_wait <= r_wait + 3'd1;
      end else begin
        r_wait <= '0;
      end
      if (r_state == S_STRB_LO && w_strb_done && !r_we) begin
        r_rdata[15:0] <= sram_dq_i;
      end
      if (r_state == S_STRB_HI && w_strb_done && !r_we) begin
        r_rdata[31:16] <= sram_dq_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_ctrl
// Purpose  : Self-checking bench for sram_ctrl: SRAM behavioural model plus a
//            word-level reference memory and read-buffer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;
  localparam int WAIT_CYCLES = 2;
  localparam int ADDR_W      = 20;
  localparam int LAT_BOTH    = 2 * (WAIT_CYCLES + 2) + 1;
  localparam int LAT_ONE     = WAIT_CYCLES + 3;
  localparam int HALF_CYC    = WAIT_CYCLES + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              bus_stb = 1'b0;
  logic              bus_we = 1'b0;
  logic [31:0]       bus_adr = '0;
  logic [31:0]       bus_dat = '0;
  logic [3:0]        bus_sel = '0;
  logic [31:0]       bus_dat_o;
  logic              bus_ack_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [15:0]       sram_dq_i = '0;
  logic [15:0]       sram_dq_o;
  logic              sram_dq_oe_o;
  logic              sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .bus_stb_i(bus_stb), .bus_we_i(bus_we), .bus_adr_i(bus_adr),
    .bus_dat_i(bus_dat), .bus_bytesel_i(bus_sel),
    .bus_dat_o(bus_dat_o), .bus_ack_o(bus_ack_o),
    .sram_addr_o(sram_addr_o), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe_o(sram_dq_oe_o), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
    .sram_we_n_o(sram_we_n_o), .sram_ub_n_o(sram_ub_n_o), .sram_lb_n_o(sram_lb_n_o)
  );

  // SRAM device model and activity monitor
  logic [15:0] sram_mem [int];
  logic [31:0] ref_word [int];
  int          ce_cnt, we_cnt, prot_viol, overlap;
  bit          cur_is_read;
  logic [ADDR_W-1:0] addr_q[$];
  logic [15:0]       dq_q[$];

  // Read-buffer reference state
  bit          buf_valid = 1'b0;
  int          buf_word  = 0;
  logic [31:0] buf_data  = '0;

  function automatic logic [15:0] mem_rd(int a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return 16'h0000;
  endfunction

  function automatic logic [31:0] ref_rd(int w);
    if (ref_word.exists(w)) return ref_word[w];
    return 32'h0;
  endfunction

  function automatic logic [31:0] bmask(logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  always @(negedge clk) begin
    logic [15:0] h;
    if (!sram_ce_n_o) begin
      ce_cnt++;
      addr_q.push_back(sram_addr_o);
      dq_q.push_back(sram_dq_o);
    end
    if (!sram_we_n_o) we_cnt++;
    if (cur_is_read && (!sram_we_n_o || sram_dq_oe_o)) prot_viol++;
    if (bus_ack_o && !sram_ce_n_o) overlap++;
    if (!sram_ce_n_o && !sram_we_n_o) begin
      h = mem_rd(int'(sram_addr_o));
      if (!sram_lb_n_o) h[7:0]  = sram_dq_o[7:0];
      if (!sram_ub_n_o) h[15:8] = sram_dq_o[15:8];
      sram_mem[int'(sram_addr_o)] = h;
    end
    sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem_rd(int'(sram_addr_o)) : 16'hDEAD;
  end

  task automatic clear_mon();
    ce_cnt = 0; we_cnt = 0; overlap = 0;
    addr_q.delete(); dq_q.delete();
  endtask

  // Drives one request; returns latency (edges from capture to ack) or -1.
  task automatic bus_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    @(posedge clk); #1;
    cur_is_read = !we;
    clear_mon();
    bus_stb = 1'b1; bus_we = we; bus_adr = adr; bus_dat = dat; bus_sel = sel;
    @(posedge clk);
    lat = -1; rdata = '0;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      #1;
      if (c == 1) begin
        // Post-capture bus changes must be ignored.
        bus_we = 1'($urandom); bus_adr = $urandom; bus_dat = $urandom; bus_sel = 4'($urandom);
      end
      if (bus_ack_o) begin
        lat = c; rdata = bus_dat_o;
      end else begin
        @(posedge clk);
      end
    end
    @(posedge clk); #1;
    bus_stb = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({bus_ack_o, bus_dat_o, sram_addr_o, sram_dq_o, sram_dq_oe_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: ack=%b dat=%h addr=%h dq=%h oe=%b, required all 0",
               bus_ack_o, bus_dat_o, sram_addr_o, sram_dq_o, sram_dq_oe_o);
    end
    n_checks++;
    if ({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o} !== 5'b11111) begin
      n_errors++;
      $display("FAIL reset_strobes: got %b required 11111",
               {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o});
    end
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus_ack_o, sram_ce_n_o} !== 2'b01) begin
      n_errors++;
      $display("FAIL idle_after_reset: ack=%b ce_n=%b required ack=0 ce_n=1", bus_ack_o, sram_ce_n_o);
    end
  endtask

  task automatic test_write_example();
    logic [31:0] rd; int lat;
    bus_txn(1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'hF, rd, lat);
    ref_word[4] = 32'hA5A5_1234;
    n_checks++;
    if (lat !== LAT_BOTH) begin
      n_errors++; $display("FAIL wr_example_latency: got %0d required %0d", lat, LAT_BOTH);
    end
    n_checks++;
    if (ce_cnt !== 2 * HALF_CYC || we_cnt !== 2 * (WAIT_CYCLES + 1)) begin
      n_errors++;
      $display("FAIL wr_example_strobes: ce_low=%0d we_low=%0d required %0d %0d",
               ce_cnt, we_cnt, 2 * HALF_CYC, 2 * (WAIT_CYCLES + 1));
    end
    n_checks++;
    if (addr_q.size() != 2 * HALF_CYC ||
        {addr_q[0], addr_q[HALF_CYC], dq_q[0], dq_q[HALF_CYC]} !== {20'h00008, 20'h00009, 16'h1234, 16'hA5A5}) begin
      n_errors++;
      $display("FAIL wr_example_sequence: n=%0d first addr/dq=%h/%h second addr/dq=%h/%h required 00008/1234 00009/a5a5",
               addr_q.size(), addr_q[0], dq_q[0], addr_q[HALF_CYC], dq_q[HALF_CYC]);
    end
    n_checks++;
    if ({mem_rd(9), mem_rd(8)} !== 32'hA5A5_1234) begin
      n_errors++; $display("FAIL wr_example_mem: got %h required a5a51234", {mem_rd(9), mem_rd(8)});
    end
  endtask

  task automatic test_read_high();
    logic [31:0] rd; int lat;
    sram_mem[9] = 16'hBEEF;
    ref_word[4][31:16] = 16'hBEEF;
    bus_txn(1'b0, 32'h0000_0010, 32'h0, 4'b1100, rd, lat);
    n_checks++;
    if (lat !== LAT_ONE) begin
      n_errors++; $display("FAIL rd_high_latency: got %0d required %0d", lat, LAT_ONE);
    end
    n_checks++;
    if (rd !== 32'hBEEF_0000) begin
      n_errors++; $display("FAIL rd_high_data: got %h required beef0000", rd);
    end
    n_checks++;
    if (ce_cnt !== HALF_CYC || addr_q.size() == 0 || addr_q[0] !== 20'h00009) begin
      n_errors++; $display("FAIL rd_high_access: ce_low=%0d required %0d at addr 00009", ce_cnt, HALF_CYC);
    end
  endtask

  task automatic test_zero_sel();
    logic [31:0] rd; int lat;
    bus_txn(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, rd, lat);
    n_checks++;
    if (lat !== 1 || ce_cnt !== 0) begin
      n_errors++; $display("FAIL zero_sel: latency=%0d ce_low=%0d required 1 and 0", lat, ce_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int acks, first_lat;
    @(posedge clk); #1;
    cur_is_read = 1'b0;
    clear_mon();
    bus_stb = 1'b1; bus_we = 1'b1; bus_adr = 32'h10; bus_dat = 32'h0F0F_F0F0; bus_sel = 4'hF;
    @(posedge clk);
    first_lat = -1;
    for (int c = 1; c <= 60 && first_lat < 0; c++) begin
      #1;
      if (bus_ack_o) first_lat = c; else @(posedge clk);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (first_lat !== LAT_BOTH || sram_ce_n_o !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_restart: first latency=%0d ce_n=%b required %0d and 0", first_lat, sram_ce_n_o, LAT_BOTH);
    end
    bus_stb = 1'b0;
    acks = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus_ack_o) acks++;
    end
    ref_word[4] = 32'h0F0F_F0F0;
    n_checks++;
    if (acks !== 1 || overlap !== 0 || ce_cnt !== 4 * HALF_CYC) begin
      n_errors++;
      $display("FAIL b2b_extra: acks=%0d overlap=%0d ce_low=%0d required 1 0 %0d", acks, overlap, ce_cnt, 4 * HALF_CYC);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat;
    @(posedge clk); #1;
    cur_is_read = 1'b0;
    bus_stb = 1'b1; bus_we = 1'b1; bus_adr = 32'h400; bus_dat = $urandom; bus_sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (sram_we_n_o !== 1'b0) begin
      n_errors++; $display("FAIL mid_strobe_active: we_n=%b required 0", sram_we_n_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus_ack_o, bus_dat_o, sram_addr_o, sram_dq_o, sram_dq_oe_o} !== '0 ||
        {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o} !== 5'b11111) begin
      n_errors++;
      $display("FAIL mid_reset_outputs: ack=%b dat=%h addr=%h dq=%h oe=%b ctl=%b required zeros and 11111",
               bus_ack_o, bus_dat_o, sram_addr_o, sram_dq_o, sram_dq_oe_o,
               {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o});
    end
    bus_stb = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({bus_ack_o, sram_ce_n_o} !== 2'b01) begin
      n_errors++; $display("FAIL mid_reset_hold: ack=%b ce_n=%b required 0 1", bus_ack_o, sram_ce_n_o);
    end
    #2 rst_n = 1'b1;
    buf_valid = 1'b0;
    bus_txn(1'b0, 32'h10, 32'h0, 4'hF, rd, lat);
    n_checks++;
    if (lat !== LAT_BOTH || rd !== ref_rd(4)) begin
      n_errors++;
      $display("FAIL after_reset_read: latency=%0d data=%h required %0d %h", lat, rd, LAT_BOTH, ref_rd(4));
    end
  endtask

  task automatic test_read_buf();
    logic [31:0] rd; int lat; int exp_lat, exp_ce;
    logic [31:0] nd;
    sram_mem[16] = 16'h5678; sram_mem[17] = 16'h9ABC;
    ref_word[8] = 32'h9ABC_5678;
    bus_txn(1'b0, 32'h20, 32'h0, 4'hF, rd, lat);
    n_checks++;
    if (lat !== LAT_BOTH || rd !== 32'h9ABC_5678) begin
      n_errors++; $display("FAIL buf_first_read: latency=%0d data=%h required %0d 9abc5678", lat, rd, LAT_BOTH);
    end
`ifdef SRAM_CTRL_READ_BUF_EN
    exp_lat = 1; exp_ce = 0;
`else
    exp_lat = LAT_BOTH; exp_ce = 2 * HALF_CYC;
`endif
    bus_txn(1'b0, 32'h20, 32'h0, 4'hF, rd, lat);
    n_checks++;
    if (lat !== exp_lat || ce_cnt !== exp_ce || rd !== 32'h9ABC_5678) begin
      n_errors++;
      $display("FAIL buf_second_read: latency=%0d ce_low=%0d data=%h required %0d %0d 9abc5678",
               lat, ce_cnt, rd, exp_lat, exp_ce);
    end
    nd = $urandom;
    bus_txn(1'b1, 32'h20, nd, 4'hF, rd, lat);
    ref_word[8] = nd;
    bus_txn(1'b0, 32'h20, 32'h0, 4'hF, rd, lat);
    n_checks++;
    if (lat !== LAT_BOTH || ce_cnt !== 2 * HALF_CYC || rd !== nd) begin
      n_errors++;
      $display("FAIL buf_after_write: latency=%0d ce_low=%0d data=%h required %0d %0d %h",
               lat, ce_cnt, rd, LAT_BOTH, 2 * HALF_CYC, nd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, adr, dat, exp_d;
    logic [3:0]  sel;
    logic        we;
    int          lat, w, exp_lat, exp_ce;
    bit          hit, lo, hi;
    @(posedge clk); #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    buf_valid = 1'b0;
    prot_viol = 0;
    for (int t = 0; t < 40; t++) begin
      we  = 1'($urandom);
      w   = int'($urandom_range(0, 7));
      adr = ($urandom & 32'hFFE0_0003) | (32'(w) << 2);
      dat = $urandom;
      sel = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      lo  = (sel[1:0] != 2'b00);
      hi  = (sel[3:2] != 2'b00);
      hit = 1'b0;
`ifdef SRAM_CTRL_READ_BUF_EN
      hit = !we && buf_valid && (buf_word == w);
`endif
      if (hit) begin
        exp_lat = 1; exp_ce = 0; exp_d = buf_data & bmask(sel);
      end else begin
        exp_lat = (lo && hi) ? LAT_BOTH : ((lo || hi) ? LAT_ONE : 1);
        exp_ce  = (int'(lo) + int'(hi)) * HALF_CYC;
        exp_d   = ref_rd(w) & {{16{hi}}, {16{lo}}};
      end
      bus_txn(we, adr, dat, sel, rd, lat);
      n_checks++;
      if (lat !== exp_lat || ce_cnt !== exp_ce) begin
        n_errors++;
        $display("FAIL rand_timing[%0d]: we=%b w=%0d sel=%b latency=%0d ce_low=%0d required %0d %0d",
                 t, we, w, sel, lat, ce_cnt, exp_lat, exp_ce);
      end
      if (!we) begin
        n_checks++;
        if (rd !== exp_d) begin
          n_errors++;
          $display("FAIL rand_read[%0d]: w=%0d sel=%b data=%h required %h", t, w, sel, rd, exp_d);
        end
        if (sel == 4'hF) begin
          buf_valid = 1'b1; buf_word = w; buf_data = ref_rd(w);
        end
      end else begin
        ref_word[w] = (ref_rd(w) & ~bmask(sel)) | (dat & bmask(sel));
        if (buf_word == w) buf_valid = 1'b0;
      end
    end
    n_checks++;
    if (prot_viol !== 0) begin
      n_errors++; $display("FAIL read_protocol: write strobes during reads=%0d required 0", prot_viol);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cur_is_read = 1'b0;
    prot_viol   = 0;
    clear_mon();
    test_reset();
    test_write_example();
    test_read_high();
    test_zero_sel();
    test_back_to_back();
    test_reset_mid();
    test_read_buf();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: extra strobe cycles per 16-bit SRAM half-access (0..7).
REQ-002 Parameter ADDR_W, default 20: SRAM halfword address width.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 bus_stb_i  input  1  request strobe from the memory bus master; held high until bus_ack_o.
REQ-006 bus_we_i  input  1  1 = write, 0 = read; valid while bus_stb_i is high.
REQ-007 bus_adr_i  input  32  byte address; bits [ADDR_W:2] are used, all other bits are ignored.
REQ-008 bus_dat_i  input  32  write data.
REQ-009 bus_bytesel_i  input  4  byte enables; bit n covers bus_dat bits [8n+7:8n].
REQ-010 bus_dat_o  output  32  read data; valid in the bus_ack_o cycle.
REQ-011 bus_ack_o  output  1  one-cycle completion pulse.
REQ-012 sram_addr_o  output  ADDR_W  halfword address: {bus_adr_i[ADDR_W:2], half}, where half 0 = low, half 1 = high.
REQ-013 sram_dq_i  input  16  SRAM read data.
REQ-014 sram_dq_o  output  16  SRAM write data.
REQ-015 sram_dq_oe_o  output  1  1 = drive sram_dq_o onto the pads.
REQ-016 sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o  output  1 each  active-low SRAM controls.

Function
REQ-017 States: IDLE, SETUP_LO, STRB_LO, SETUP_HI, STRB_HI, ACK.
REQ-018 In IDLE with bus_stb_i=1 at a clock edge: latch adr, we, dat and bytesel; select the next state using the latched bytesel:
- bytesel[1:0]!=0: SETUP_LO.
- else bytesel[3:2]!=0: SETUP_HI.
- else: ACK.
REQ-019 SETUP_x lasts 1 cycle:
- ce_n=0; ub_n/lb_n = ~bytesel bits of that half.
- Read: oe_n=0.
- Write: dq_oe=1 and dq_o = the selected data half.
REQ-020 STRB_x lasts WAIT_CYCLES+1 cycles with the SETUP_x signals held.
- Write: we_n=0 for the whole STRB_x.
- Read: sram_dq_i is captured into the matching bus_dat_o half at the edge that leaves STRB_x.
REQ-021 Next state after STRB_LO: SETUP_HI if latched bytesel[3:2]!=0, else ACK. Next state after STRB_HI: ACK.
REQ-022 ACK lasts 1 cycle:
- bus_ack_o=1; ce_n, oe_n and we_n are 1; dq_oe=0.
- Next state is always IDLE; bus_stb_i is not sampled in ACK.
REQ-023 Read bytes whose halves were not accessed return 0 in bus_dat_o.
REQ-024 Latency, counted in cycles from the request-capture edge to bus_ack_o high:
- Both halves: 2*(WAIT_CYCLES+2)+1 (9 at the default).
- One half: WAIT_CYCLES+3 (5 at the default).
- bytesel=0000: 1; no SRAM activity.
REQ-025 The master drops bus_stb_i in the cycle after bus_ack_o. A bus_stb_i still high when IDLE is re-entered starts a new access (defined behaviour, not an error).
REQ-026 Changes on bus inputs after the capture edge are ignored until IDLE.
REQ-027 Outside SETUP/STRB: ce_n=oe_n=we_n=ub_n=lb_n=1 and dq_oe=0. we_n and dq_oe are never active during a read.

Reset
REQ-028 rst_i=0 immediately forces:
- state IDLE and bus_ack_o=0;
- bus_dat_o=0 and sram_addr_o=0;
- sram_dq_o=0 and dq_oe=0;
- all sram_*_n_o=1.
REQ-029 Reset mid-access aborts the access; no ack is issued, and the SRAM write may be partial.

Configuration
REQ-030 Macro SRAM_CTRL_READ_BUF_EN defined: a single-entry read buffer is compiled in. It holds {valid, word address, 32-bit data}.
- Fill: any read with bytesel=1111 completes.
- Hit: a read in IDLE whose word address matches a valid entry goes directly to ACK; latency 1; bus_dat_o is the buffered word masked by bytesel; no SRAM activity.
- Invalidate: a write to the same word, or reset, clears valid.
REQ-031 Macro undefined: no buffer; every read accesses SRAM per REQ-018..022.

Verification
REQ-032 Reset with rst_i=0 asserted mid-STRB_LO of a write -> all outputs at their reset values in the same cycle; the next stb then starts cleanly from IDLE.
REQ-033 Write adr=0x0000_0010, dat=0xA5A5_1234, sel=1111, WAIT_CYCLES=2:
- sram_addr 0x00008, then 0x00009; dq_o 0x1234, then 0xA5A5.
- we_n low for 3 cycles per half.
- ack in cycle 9.
REQ-034 Read adr=0x10 with sel=1100 and SRAM returning 0xBEEF at halfword 0x00009 -> only the high half is accessed; bus_dat_o=0xBEEF_0000; ack in cycle 5.
REQ-035 Write with sel=0000 -> ack in cycle 1; ce_n stays 1 throughout.
REQ-036 bus_stb_i held high for 2 cycles after ack -> exactly one extra access starts from IDLE, with no overlap with ACK.
REQ-037 With SRAM_CTRL_READ_BUF_EN: read 0x20 sel=1111, read 0x20 again, write 0x20, read 0x20:
- Second read: ack in cycle 1 with no ce_n activity.
- Final read: accesses SRAM again.
